spi_seq: RTL and testbench

SPI_SEQ -- requirements
Module: spi_seq

---
 rtl/spi_seq_pkg.sv | 43 ++++
 rtl/spi_seq_fifo.sv | 78 +++++++
 rtl/spi_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared definitions for the port-mapped SPI burst sequencer.
//   - state_e       : sequencer FSM states
//   - OFF_*         : port offsets relative to the block base address
//   - STAT_*        : bit positions inside the status byte
//   - pack_status() : assembles the status byte from its flags
package spi_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic [7:0] OFF_DATA  = 8'd0;
    localparam logic [7:0] OFF_CMD   = 8'd1;
    localparam logic [7:0] OFF_START = 8'd2;
    localparam logic [7:0] OFF_STAT  = 8'd3;
    localparam logic [7:0] OFF_LVL   = 8'd4;

    localparam int STAT_BUSY  = 7;
    localparam int STAT_EMPTY = 6;
    localparam int STAT_FULL  = 5;
    localparam int STAT_OVF   = 4;
    localparam int STAT_TMO   = 3;

    function automatic logic [7:0] pack_status(
        input logic busy,
        input logic empty,
        input logic full,
        input logic ovf,
        input logic tmo
    );
        logic [7:0] s;
        s             = 8'h00;
        s[STAT_BUSY]  = busy;
        s[STAT_EMPTY] = empty;
        s[STAT_FULL]  = full;
        s[STAT_OVF]   = ovf;
        s[STAT_TMO]   = tmo;
        return s;
    endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// spi_seq_fifo: synchronous receive FIFO, 2^AW bytes deep.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears pointers/level)
//   push, din     : write request and byte
//   pop           : read request; head is the byte being popped
//   head          : oldest byte, 8'hFF while empty
//   level         : occupancy 0..2^AW (AW+1 bits)
//   full, empty   : occupancy flags
//   drop          : push rejected this cycle (full with no same-cycle pop)
module spi_seq_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    head,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          drop
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify requests: a pop frees a slot, so push-at-full succeeds alongside it.
    always_comb begin
        empty     = (level_r == (AW + 1)'(0));
        full      = (level_r == LVL_FULL);
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        drop      = push && full && !do_pop_s;
        level     = level_r;
        if (empty) begin
            head = 8'hFF;
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

    // Storage array; at full the write slot equals the slot being popped, which is safe.
    always_ff @(posedge clk) begin
        if (do_push_s && !rst) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally at 2^AW; level tracks net push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + (AW + 1)'(1);
                2'b01:   level_r <= level_r - (AW + 1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/spi_seq.sv
// spi_seq: CPU port-mapped sequencer that drives a byte SPI engine for bursts
// of 1..256 bytes and collects received bytes into a FIFO.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   pin_pa/po/pw/pr   : CPU port address, write data, write strobe, read strobe
//   pin_pi            : port read data (combinational, 8'hFF when not decoded)
//   eng_start         : one-cycle engine request (only in ISSUE)
//   eng_cmd, eng_tx   : command and fill byte, held stable through a burst
//   eng_done, eng_rx  : engine completion pulse and received byte
//   busy              : sequencer not idle
// Port map: BASE+0 fill / FIFO pop, BASE+1 cmd, BASE+2 start burst (0 = 256),
//   BASE+3 status {busy,empty,full,ovf,tmo,000} (read clears ovf/tmo), BASE+4 level.
// Build option: define SPI_SEQ_TIMEOUT_EN to include the WAIT-state watchdog.
module spi_seq
    import spi_seq_pkg::*;
#(
    parameter logic [7:0] BASE        = 8'hF0,
    parameter int          FIFO_AW     = 4,
    parameter int          TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pin_pa,
    input  logic [7:0] pin_po,
    input  logic       pin_pw,
    input  logic       pin_pr,
    output logic [7:0] pin_pi,
    output logic       eng_start,
    output logic [1:0] eng_cmd,
    output logic [7:0] eng_tx,
    input  logic       eng_done,
    input  logic [7:0] eng_rx,
    output logic       busy
);

    localparam logic [7:0] ADDR_DATA  = BASE + OFF_DATA;
    localparam logic [7:0] ADDR_CMD   = BASE + OFF_CMD;
    localparam logic [7:0] ADDR_START = BASE + OFF_START;
    localparam logic [7:0] ADDR_STAT  = BASE + OFF_STAT;
    localparam logic [7:0] ADDR_LVL   = BASE + OFF_LVL;

    state_e        state_r;
    state_e        state_next_s;
    logic [8:0]    remaining_r;
    logic [8:0]    remaining_next_s;
    logic [7:0]    fill_r;
    logic [1:0]    cmd_r;
    logic          eng_start_r;
    logic          busy_r;
    logic          ovf_r;
    logic          tmo_bit_s;
    logic          tmo_hit_s;

    logic          idle_s;
    logic          wr_fill_s;
    logic          wr_cmd_s;
    logic          wr_start_s;
    logic          rd_stat_s;
    logic          pop_s;
    logic          push_s;

    logic [7:0]    fifo_head_s;
    logic [FIFO_AW:0] fifo_level_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          fifo_drop_s;

    // Port strobe decode; configuration writes only land while idle.
    always_comb begin
        idle_s     = (state_r == ST_IDLE);
        wr_fill_s  = pin_pw && (pin_pa == ADDR_DATA)  && idle_s;
        wr_cmd_s   = pin_pw && (pin_pa == ADDR_CMD)   && idle_s;
        wr_start_s = pin_pw && (pin_pa == ADDR_START) && idle_s;
        rd_stat_s  = pin_pr && (pin_pa == ADDR_STAT);
        pop_s      = pin_pr && (pin_pa == ADDR_DATA);
        push_s     = eng_done && (state_r == ST_WAIT);
    end

    spi_seq_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (eng_rx),
        .head  (fifo_head_s),
        .level (fifo_level_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .drop  (fifo_drop_s)
    );

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wdog_r;
    logic            tmo_r;

    // Watchdog counts consecutive WAIT cycles without a completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_r <= '0;
        end else if ((state_r == ST_WAIT) && !eng_done && !tmo_hit_s) begin
            wdog_r <= wdog_r + WD_W'(1);
        end else begin
            wdog_r <= '0;
        end
    end

    // Sticky timeout flag, cleared by a status read unless a new timeout lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_r <= 1'b0;
        end else if (tmo_hit_s) begin
            tmo_r <= 1'b1;
        end else if (rd_stat_s) begin
            tmo_r <= 1'b0;
        end
    end

    assign tmo_bit_s = tmo_r;
`else
    logic unused_s;
    assign unused_s  = ^TIMEOUT_CYC;
    assign tmo_bit_s = 1'b0;
`endif

    // Next-state logic; remaining count holds bytes still to be completed.
    always_comb begin
        state_next_s     = state_r;
        remaining_next_s = remaining_r;
        tmo_hit_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wr_start_s) begin
                    state_next_s = ST_ISSUE;
                    if (pin_po == 8'd0) begin
                        remaining_next_s = 9'd256;
                    end else begin
                        remaining_next_s = {1'b0, pin_po};
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done) begin
                    remaining_next_s = remaining_r - 9'd1;
                    if (remaining_r == 9'd1) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_ISSUE;
                    end
                end
`ifdef SPI_SEQ_TIMEOUT_EN
                else if (wdog_r == WD_LAST) begin
                    tmo_hit_s        = 1'b1;
                    state_next_s     = ST_IDLE;
                    remaining_next_s = 9'd0;
                end
`endif
                else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                state_next_s     = ST_IDLE;
                remaining_next_s = 9'd0;
            end
        endcase
    end

    // State, burst count and registered engine handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            remaining_r <= 9'd0;
            eng_start_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            remaining_r <= remaining_next_s;
            eng_start_r <= (state_next_s == ST_ISSUE);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    // Fill byte and engine command registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_r <= 8'hFF;
            cmd_r  <= 2'b00;
        end else begin
            if (wr_fill_s) begin
                fill_r <= pin_po;
            end
            if (wr_cmd_s) begin
                cmd_r <= pin_po[1:0];
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a status read wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (fifo_drop_s) begin
            ovf_r <= 1'b1;
        end else if (rd_stat_s) begin
            ovf_r <= 1'b0;
        end
    end

    // Port read mux.
    always_comb begin
        pin_pi = 8'hFF;
        case (pin_pa)
            ADDR_DATA: pin_pi = fifo_head_s;
            ADDR_STAT: pin_pi = pack_status(busy_r, fifo_empty_s, fifo_full_s,
                                            ovf_r, tmo_bit_s);
            ADDR_LVL:  pin_pi = 8'(fifo_level_s);
            default:   pin_pi = 8'hFF;
        endcase
    end

    assign eng_start = eng_start_r;
    assign busy      = busy_r;
    assign eng_tx    = fill_r;
    assign eng_cmd   = cmd_r;

endmodule

// File: tb/tb_spi_seq.sv
// tb_spi_seq: directed self-checking bench for spi_seq.
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_spi_seq;

    localparam logic [7:0] BASE = 8'hF0;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pin_pa;
    logic [7:0] pin_po;
    logic       pin_pw;
    logic       pin_pr;
    logic [7:0] pin_pi;
    logic       eng_start;
    logic [1:0] eng_cmd;
    logic [7:0] eng_tx;
    logic       eng_done;
    logic [7:0] eng_rx;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;

    spi_seq #(
        .BASE        (BASE),
        .FIFO_AW     (4),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pin_pa    (pin_pa),
        .pin_po    (pin_po),
        .pin_pw    (pin_pw),
        .pin_pr    (pin_pr),
        .pin_pi    (pin_pi),
        .eng_start (eng_start),
        .eng_cmd   (eng_cmd),
        .eng_tx    (eng_tx),
        .eng_done  (eng_done),
        .eng_rx    (eng_rx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Count engine requests as seen by the engine on each rising edge.
    always @(posedge clk) begin
        if (eng_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic port_wr(input logic [7:0] addr, input logic [7:0] data);
        pin_pa = addr;
        pin_po = data;
        pin_pw = 1'b1;
        tick();
        pin_pw = 1'b0;
    endtask

    task automatic port_rd(input logic [7:0] addr, output logic [7:0] data);
        pin_pa = addr;
        pin_pr = 1'b1;
        #1 data = pin_pi;
        tick();
        pin_pr = 1'b0;
    endtask

    task automatic peek(input logic [7:0] addr, output logic [7:0] data);
        pin_pa = addr;
        pin_pr = 1'b0;
        #1 data = pin_pi;
    endtask

    task automatic wait_start(input string tag);
        int k;
        k = 0;
        while (eng_start !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check(tag, {31'd0, eng_start}, 32'd1);
    endtask

    // Engine model: answer each request 4 cycles later with rx_base+i.
    task automatic serve(input int n, input logic [7:0] rx_base, input logic [7:0] exp_tx);
        for (int i = 0; i < n; i++) begin
            wait_start("serve_start");
            check("serve_tx", {24'd0, eng_tx}, {24'd0, exp_tx});
            repeat (3) tick();
            eng_done = 1'b1;
            eng_rx   = rx_base + 8'(i);
            tick();
            eng_done = 1'b0;
            if (i < n - 1) check("serve_restart", {31'd0, eng_start}, 32'd1);
        end
    endtask

    initial begin
        logic [7:0] d;
        int c0;

        rst = 1'b1; pin_pa = 8'h00; pin_po = 8'h00; pin_pw = 1'b0; pin_pr = 1'b0;
        eng_done = 1'b0; eng_rx = 8'h00;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_start", {31'd0, eng_start}, 32'd0);
        check("rst_tx", {24'd0, eng_tx}, 32'h0000_00FF);
        check("rst_cmd", {30'd0, eng_cmd}, 32'd0);
        peek(BASE + 8'd3, d); check("rst_status", {24'd0, d}, 32'h0000_0040);
        peek(BASE + 8'd4, d); check("rst_level", {24'd0, d}, 32'd0);
        peek(BASE + 8'd5, d); check("undecoded", {24'd0, d}, 32'h0000_00FF);
        tick();

        // Three-byte burst
        port_wr(BASE + 8'd0, 8'hA5);
        port_wr(BASE + 8'd1, 8'h02);
        check("cmd", {30'd0, eng_cmd}, 32'd2);
        c0 = start_cnt;
        port_wr(BASE + 8'd2, 8'd3);
        check("start_latency", {31'd0, eng_start}, 32'd1);
        port_wr(BASE + 8'd0, 8'h3C);
        port_wr(BASE + 8'd1, 8'h01);
        port_wr(BASE + 8'd2, 8'd7);
        check("busy_in_burst", {31'd0, busy}, 32'd1);
        check("tx_stable", {24'd0, eng_tx}, 32'h0000_00A5);
        check("cmd_stable", {30'd0, eng_cmd}, 32'd2);
        eng_done = 1'b1; eng_rx = 8'd10;
        tick();
        eng_done = 1'b0;
        check("done_restart", {31'd0, eng_start}, 32'd1);
        serve(2, 8'd11, 8'hA5);
        check("burst3_idle", {31'd0, busy}, 32'd0);
        repeat (3) tick();
        check("burst3_starts", start_cnt - c0, 32'd3);
        peek(BASE + 8'd4, d); check("burst3_level", {24'd0, d}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            port_rd(BASE + 8'd0, d);
            check("burst3_pop", {24'd0, d}, 32'd10 + i);
        end
        port_rd(BASE + 8'd0, d); check("pop_empty", {24'd0, d}, 32'h0000_00FF);
        peek(BASE + 8'd4, d); check("pop_empty_level", {24'd0, d}, 32'd0);
        tick();

        // 256-byte burst with overflow
        c0 = start_cnt;
        port_wr(BASE + 8'd2, 8'd0);
        serve(256, 8'h20, 8'hA5);
        repeat (5) tick();
        check("burst256_starts", start_cnt - c0, 32'd256);
        check("burst256_idle", {31'd0, busy}, 32'd0);
        peek(BASE + 8'd4, d); check("burst256_level", {24'd0, d}, 32'd16);
        port_rd(BASE + 8'd3, d); check("ovf_status", {24'd0, d}, 32'h0000_0030);
        port_rd(BASE + 8'd3, d); check("ovf_cleared", {24'd0, d}, 32'h0000_0020);

        // Pop and push together at full
        port_wr(BASE + 8'd2, 8'd1);
        wait_start("full_start");
        tick();
        eng_done = 1'b1; eng_rx = 8'h77;
        pin_pa = BASE; pin_pr = 1'b1;
        #1 d = pin_pi;
        check("full_pop_oldest", {24'd0, d}, 32'h0000_0020);
        tick();
        eng_done = 1'b0; pin_pr = 1'b0;
        check("full_idle", {31'd0, busy}, 32'd0);
        peek(BASE + 8'd4, d); check("full_level", {24'd0, d}, 32'd16);
        peek(BASE + 8'd3, d); check("full_no_ovf", {24'd0, d}, 32'h0000_0020);
        tick();
        for (int i = 0; i < 15; i++) begin
            port_rd(BASE + 8'd0, d);
            check("drain", {24'd0, d}, 32'h21 + i);
        end
        port_rd(BASE + 8'd0, d); check("drain_last", {24'd0, d}, 32'h0000_0077);
        port_rd(BASE + 8'd1, d);
        peek(BASE + 8'd3, d); check("drained_status", {24'd0, d}, 32'h0000_0040);
        tick();

        // Reset in the middle of a burst, then a late completion
        port_wr(BASE + 8'd0, 8'h5A);
        port_wr(BASE + 8'd2, 8'd5);
        tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_start", {31'd0, eng_start}, 32'd0);
        check("mid_rst_tx", {24'd0, eng_tx}, 32'h0000_00FF);
        c0 = start_cnt;
        tick();
        eng_done = 1'b1; eng_rx = 8'h55;
        tick();
        eng_done = 1'b0;
        repeat (10) tick();
        check("late_done_busy", {31'd0, busy}, 32'd0);
        check("late_done_starts", start_cnt - c0, 32'd0);
        peek(BASE + 8'd4, d); check("late_done_level", {24'd0, d}, 32'd0);
        tick();

        // Engine never answers
        port_wr(BASE + 8'd2, 8'd2);
`ifdef SPI_SEQ_TIMEOUT_EN
        repeat (20) tick();
        check("tmo_before", {31'd0, busy}, 32'd1);
        tick();
        check("tmo_idle", {31'd0, busy}, 32'd0);
        port_rd(BASE + 8'd3, d); check("tmo_status", {24'd0, d}, 32'h0000_0048);
        peek(BASE + 8'd3, d); check("tmo_cleared", {24'd0, d}, 32'h0000_0040);
`else
        repeat (40) tick();
        check("no_tmo_busy", {31'd0, busy}, 32'd1);
        peek(BASE + 8'd3, d); check("no_tmo_status", {24'd0, d}, 32'h0000_00C0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("final_rst_busy", {31'd0, busy}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
